read_data_collector: RTL and testbench
======================================

READ_DATA_COLLECTOR -- requirements
Module: read_data_collector

Interface
REQ-001 SHALL have parameter N_CH, default 9, meaning number of read-data sources.
REQ-002 SHALL have parameter DATA_W, default 8, meaning read-data width in bits.
REQ-003 SHALL have parameter TIMEOUT, default 16, meaning max WAIT cycles before a read is aborted; legal range 1..255.
REQ-004 SHALL have port i_clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port i_rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port i_rd_req  input  1  read request, one-cycle pulse.
REQ-007 SHALL have port i_rd_sel  input  N_CH  one-hot target channel, sampled with i_rd_req.
REQ-008 SHALL have port i_ch_data  input  N_CH*DATA_W  channel c data in bits [c*DATA_W +: DATA_W].
REQ-009 SHALL have port i_ch_valid  input  N_CH  per-channel data-valid.
REQ-010 SHALL have port o_busy  output  1  high in any state other than IDLE.
REQ-011 SHALL have port o_data  output  DATA_W  returned read data, registered.
REQ-012 SHALL have port o_data_valid  output  1  one-cycle response strobe.
REQ-013 SHALL have port o_err_timeout  output  1  response was a timeout; valid with o_data_valid.
REQ-014 SHALL have port o_err_collision  output  1  non-selected channel asserted valid in the capture cycle; valid with o_data_valid.
REQ-015 SHALL have port o_err_sel  output  1  i_rd_sel was zero or not one-hot; valid with o_data_valid.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, RESP; reset state IDLE.
REQ-017 IDLE: on i_rd_req=1 with one-hot i_rd_sel, SHALL latch i_rd_sel, clear the timeout counter, go to WAIT.
REQ-018 IDLE: on i_rd_req=1 with i_rd_sel zero or multi-hot, SHALL go to RESP with o_data=0, o_err_sel=1, other error flags 0.
REQ-019 i_ch_valid SHALL be ignored in IDLE; it is sampled only in WAIT.
REQ-020 WAIT: when the latched channel's i_ch_valid=1, SHALL register that channel's data into o_data and go to RESP.
REQ-021 WAIT capture cycle: if any other i_ch_valid bit is also 1, SHALL set o_err_collision=1; o_data still carries the selected channel only.
REQ-022 WAIT: each cycle without selected valid SHALL increment the counter (width $clog2(TIMEOUT+1)); after TIMEOUT such cycles SHALL go to RESP with o_data=0, o_err_timeout=1.
REQ-023 Selected valid in the same cycle the counter reaches TIMEOUT SHALL win: normal capture, no timeout flag.
REQ-024 RESP: o_data_valid SHALL be 1 for exactly one cycle, then IDLE unconditionally.
REQ-025 Latency: request sampled at edge T0, selected valid sampled at edge Tk (k>=1) -> o_data_valid high in the cycle after edge Tk; minimum 2 cycles from request to response.
REQ-026 i_rd_req in WAIT or RESP SHALL be ignored (no queueing); the requester gates on o_busy.
REQ-027 o_data and error flags SHALL hold their values after the strobe until the next RESP.
REQ-028 Error flags SHALL be mutually exclusive except collision, which occurs only on a successful capture.

Reset
REQ-029 i_rst=1 SHALL force IDLE, counter 0, latched select 0, o_data=0, o_data_valid=0, all error flags 0, o_busy=0 at the next edge, including mid-WAIT; an aborted read SHALL produce no response.

Verification
REQ-030 N_CH=9, DATA_W=8: req sel=9'h004, channel 2 valid 3 cycles later with data 8'hA5 -> one o_data_valid strobe, o_data=8'hA5, all error flags 0.
REQ-031 TIMEOUT=4: req sel=9'h001, no valid -> after 4 WAIT cycles one strobe, o_data=8'h00, o_err_timeout=1.
REQ-032 req sel=9'h010, capture cycle i_ch_valid=9'h011 with ch4=8'h3C, ch0=8'hFF -> o_data=8'h3C, o_err_collision=1.
REQ-033 req sel=9'h000, then req sel=9'h006 -> each gives a strobe in the next cycle with o_err_sel=1, o_data=0.
REQ-034 i_rst pulse mid-WAIT, then selected valid -> no strobe, all outputs 0, o_busy=0; a fresh req afterwards completes normally.
REQ-035 second i_rd_req while o_busy=1 -> ignored; exactly one response for the first request; selected valid at the exact TIMEOUT cycle -> data returned, o_err_timeout=0.

Source files
------------

// File: rtl/read_data_collector.sv
// Read-data collector: routes one read request to a one-hot selected channel,
// waits (bounded) for that channel's data-valid, and returns a single
// registered response strobe with data and error flags.
module read_data_collector #(
   parameter int N_CH    = 9,
   parameter int DATA_W  = 8,
   parameter int TIMEOUT = 16
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_rd_req,
   input  logic [N_CH-1:0]          i_rd_sel,
   input  logic [N_CH*DATA_W-1:0]   i_ch_data,
   input  logic [N_CH-1:0]          i_ch_valid,
   output logic                     o_busy,
   output logic [DATA_W-1:0]        o_data,
   output logic                     o_data_valid,
   output logic                     o_err_timeout,
   output logic                     o_err_collision,
   output logic                     o_err_sel
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [N_CH-1:0]     sel_q, sel_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic                dv_q, dv_d;
   logic                eto_q, eto_d;
   logic                ecol_q, ecol_d;
   logic                esel_q, esel_d;
   logic                busy_q, busy_d;

   logic [DATA_W-1:0]   sel_data;
   logic                sel_onehot;
   logic                sel_hit;
   logic                other_hit;
   logic [CNT_W-1:0]    cnt_inc;

   // Mux the latched channel's data; sel_q is one-hot (or zero) so OR-ing is exact.
   always_comb begin
      sel_data = '0;
      for (int c = 0; c < N_CH; c++) begin
         if (sel_q[c]) sel_data = sel_data | i_ch_data[c*DATA_W +: DATA_W];
      end
   end

   // Request decode and capture-cycle status terms.
   always_comb begin
      sel_onehot = (i_rd_sel != '0) && ((i_rd_sel & (i_rd_sel - N_CH'(1))) == '0);
      sel_hit    = |(i_ch_valid & sel_q);
      other_hit  = |(i_ch_valid & ~sel_q);
      cnt_inc    = cnt_q + CNT_W'(1);
   end

   // Next-state logic; response fields only change on entry to RESP so they
   // hold their value after the strobe.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sel_d   = sel_q;
      data_d  = data_q;
      dv_d    = 1'b0;
      eto_d   = eto_q;
      ecol_d  = ecol_q;
      esel_d  = esel_q;
      case (state_q)
         S_IDLE: begin
            if (i_rd_req) begin
               if (sel_onehot) begin
                  sel_d   = i_rd_sel;
                  cnt_d   = '0;
                  state_d = S_WAIT;
               end else begin
                  data_d  = '0;
                  eto_d   = 1'b0;
                  ecol_d  = 1'b0;
                  esel_d  = 1'b1;
                  dv_d    = 1'b1;
                  state_d = S_RESP;
               end
            end
         end
         S_WAIT: begin
            // Selected valid has priority over the timeout in the same cycle.
            if (sel_hit) begin
               data_d  = sel_data;
               eto_d   = 1'b0;
               ecol_d  = other_hit;
               esel_d  = 1'b0;
               dv_d    = 1'b1;
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_inc;
               if (cnt_inc == CNT_W'(TIMEOUT)) begin
                  data_d  = '0;
                  eto_d   = 1'b1;
                  ecol_d  = 1'b0;
                  esel_d  = 1'b0;
                  dv_d    = 1'b1;
                  state_d = S_RESP;
               end
            end
         end
         S_RESP: begin
            sel_d   = '0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   // State and registered outputs; synchronous reset aborts any read silently.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         sel_q   <= '0;
         data_q  <= '0;
         dv_q    <= 1'b0;
         eto_q   <= 1'b0;
         ecol_q  <= 1'b0;
         esel_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sel_q   <= sel_d;
         data_q  <= data_d;
         dv_q    <= dv_d;
         eto_q   <= eto_d;
         ecol_q  <= ecol_d;
         esel_q  <= esel_d;
         busy_q  <= busy_d;
      end
   end

   assign o_busy          = busy_q;
   assign o_data          = data_q;
   assign o_data_valid    = dv_q;
   assign o_err_timeout   = eto_q;
   assign o_err_collision = ecol_q;
   assign o_err_sel       = esel_q;

endmodule

// File: tb/tb_read_data_collector.sv
// Directed bench for read_data_collector (N_CH=9, DATA_W=8, TIMEOUT=4).
module tb_read_data_collector;

   localparam int N_CH    = 9;
   localparam int DATA_W  = 8;
   localparam int TIMEOUT = 4;

   logic                          i_clk = 1'b0;
   logic                          i_rst;
   logic                          i_rd_req;
   logic [N_CH-1:0]               i_rd_sel;
   logic [N_CH-1:0][DATA_W-1:0]   ch_data;
   logic [N_CH-1:0]               i_ch_valid;
   logic                          o_busy;
   logic [DATA_W-1:0]             o_data;
   logic                          o_data_valid;
   logic                          o_err_timeout;
   logic                          o_err_collision;
   logic                          o_err_sel;

   int tests = 0;
   int fails = 0;
   int strobes = 0;

   // {busy, data_valid, err_timeout, err_collision, err_sel, data}
   wire [12:0] obs = {o_busy, o_data_valid, o_err_timeout, o_err_collision, o_err_sel, o_data};

   read_data_collector #(.N_CH(N_CH), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
      .i_clk           (i_clk),
      .i_rst           (i_rst),
      .i_rd_req        (i_rd_req),
      .i_rd_sel        (i_rd_sel),
      .i_ch_data       (ch_data),
      .i_ch_valid      (i_ch_valid),
      .o_busy          (o_busy),
      .o_data          (o_data),
      .o_data_valid    (o_data_valid),
      .o_err_timeout   (o_err_timeout),
      .o_err_collision (o_err_collision),
      .o_err_sel       (o_err_sel)
   );

   always #5 i_clk = ~i_clk;

   // Advance one edge, settle, and tally any response strobe.
   task automatic step();
      @(posedge i_clk);
      #1;
      if (o_data_valid === 1'b1) strobes++;
   endtask

   task automatic req(input logic [N_CH-1:0] sel);
      i_rd_req = 1'b1;
      i_rd_sel = sel;
      step();
      i_rd_req = 1'b0;
      i_rd_sel = '0;
   endtask

   task automatic test_reset();
      i_rst = 1'b1; i_rd_req = 1'b0; i_rd_sel = '0; i_ch_valid = '0; ch_data = '0;
      step(); step();
      tests++;
      if (obs !== 13'h0000) begin
         fails++; $display("FAIL reset_state: got %h expected %h", obs, 13'h0000);
      end
      i_rst = 1'b0;
      step();
      tests++;
      if (obs !== 13'h0000) begin
         fails++; $display("FAIL reset_idle: got %h expected %h", obs, 13'h0000);
      end
   endtask

   task automatic test_normal();
      strobes = 0;
      ch_data[2] = 8'hA5;
      req(9'h004);
      tests++;
      if (obs !== {5'b10000, 8'h00}) begin
         fails++; $display("FAIL normal_wait_entry: got %h expected %h", obs, {5'b10000, 8'h00});
      end
      step(); step();
      i_ch_valid = 9'h004;
      step();
      tests++;
      if (obs !== {5'b11000, 8'hA5}) begin
         fails++; $display("FAIL normal_resp: got %h expected %h", obs, {5'b11000, 8'hA5});
      end
      i_ch_valid = '0;
      step();
      tests++;
      if (obs !== {5'b00000, 8'hA5} || strobes != 1) begin
         fails++; $display("FAIL normal_hold: got %h/%0d expected %h/1", obs, strobes, {5'b00000, 8'hA5});
      end
   endtask

   task automatic test_timeout();
      strobes = 0;
      req(9'h001);
      step(); step(); step();
      tests++;
      if (strobes != 0 || o_busy !== 1'b1) begin
         fails++; $display("FAIL timeout_early: got strobes %0d busy %b expected 0 1", strobes, o_busy);
      end
      step();
      tests++;
      if (obs !== {5'b11100, 8'h00}) begin
         fails++; $display("FAIL timeout_resp: got %h expected %h", obs, {5'b11100, 8'h00});
      end
      step();
      tests++;
      if (obs !== {5'b00100, 8'h00} || strobes != 1) begin
         fails++; $display("FAIL timeout_hold: got %h/%0d expected %h/1", obs, strobes, {5'b00100, 8'h00});
      end
   endtask

   task automatic test_collision();
      ch_data[4] = 8'h3C;
      ch_data[0] = 8'hFF;
      req(9'h010);
      i_ch_valid = 9'h011;
      step();
      tests++;
      if (obs !== {5'b11010, 8'h3C}) begin
         fails++; $display("FAIL collision_resp: got %h expected %h", obs, {5'b11010, 8'h3C});
      end
      i_ch_valid = '0;
      step();
      tests++;
      if (obs !== {5'b00010, 8'h3C}) begin
         fails++; $display("FAIL collision_hold: got %h expected %h", obs, {5'b00010, 8'h3C});
      end
   endtask

   task automatic test_sel_err();
      req(9'h000);
      tests++;
      if (obs !== {5'b11001, 8'h00}) begin
         fails++; $display("FAIL sel_zero: got %h expected %h", obs, {5'b11001, 8'h00});
      end
      step();
      req(9'h006);
      tests++;
      if (obs !== {5'b11001, 8'h00}) begin
         fails++; $display("FAIL sel_multi: got %h expected %h", obs, {5'b11001, 8'h00});
      end
      step();
      tests++;
      if (obs !== {5'b00001, 8'h00}) begin
         fails++; $display("FAIL sel_hold: got %h expected %h", obs, {5'b00001, 8'h00});
      end
   endtask

   task automatic test_reset_mid_wait();
      strobes = 0;
      ch_data[1] = 8'h5A;
      req(9'h002);
      step();
      i_rst = 1'b1;
      i_ch_valid = 9'h002;
      step();
      tests++;
      if (obs !== 13'h0000) begin
         fails++; $display("FAIL midwait_reset: got %h expected %h", obs, 13'h0000);
      end
      i_rst = 1'b0;
      step(); step(); step();
      tests++;
      if (obs !== 13'h0000 || strobes != 0) begin
         fails++; $display("FAIL midwait_no_resp: got %h/%0d expected %h/0", obs, strobes, 13'h0000);
      end
      req(9'h002);
      step();
      tests++;
      if (obs !== {5'b11000, 8'h5A}) begin
         fails++; $display("FAIL midwait_fresh: got %h expected %h", obs, {5'b11000, 8'h5A});
      end
      i_ch_valid = '0;
      step();
   endtask

   task automatic test_back_to_back();
      strobes = 0;
      ch_data[3] = 8'h77;
      req(9'h008);
      i_rd_req = 1'b1;
      i_rd_sel = 9'h001;
      step();
      i_rd_req = 1'b0;
      i_rd_sel = '0;
      step(); step();
      i_ch_valid = 9'h008;
      step();
      tests++;
      if (obs !== {5'b11000, 8'h77}) begin
         fails++; $display("FAIL edge_timeout_capture: got %h expected %h", obs, {5'b11000, 8'h77});
      end
      i_ch_valid = '0;
      step(); step(); step();
      tests++;
      if (obs !== {5'b00000, 8'h77} || strobes != 1) begin
         fails++; $display("FAIL b2b_single_resp: got %h/%0d expected %h/1", obs, strobes, {5'b00000, 8'h77});
      end
   endtask

   initial begin
      test_reset();
      test_normal();
      test_timeout();
      test_collision();
      test_sel_err();
      test_reset_mid_wait();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
